stack_ctrl: RTL
===============

Name: stack_ctrl

Overview:
Sequencer for the CPU stack. Accepts PUSH/POP/CALL/RET commands from the control unit and maintains the stack pointer register. Drives the single-port data-memory handshake and loads the PC on CALL/RET. Flags overflow and underflow instead of corrupting memory.

Parameters:
W, 16, data/address width
SP_BASE, 16'h0400, SP value when the stack is empty (full-descending stack; SP points at the last pushed word)
SP_LIMIT, 16'h03F0, lowest legal SP value (SP==SP_LIMIT means full; 16 entries at defaults)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  command request
op_ready  out  1  block can accept a command (high only in IDLE)
op_code  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
op_data  in  W  PUSH data / CALL return address
op_target  in  W  CALL jump target
done  out  1  one-cycle completion pulse
rd_data  out  W  POP result, held until the next POP/RET completes
pc_load  out  1  one-cycle PC load strobe, coincident with done
pc_value  out  W  PC value for pc_load
err_overflow  out  1  done-cycle flag: PUSH/CALL refused, stack full
err_underflow  out  1  done-cycle flag: POP/RET refused, stack empty
mem_req  out  1  memory access request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  W  memory address
mem_wdata  out  W  write data
mem_rdata  in  W  read data, valid when mem_ack=1
mem_ack  in  1  access complete
sp  out  W  current stack pointer

Behaviour:
- Reset (async, immediate): state IDLE; sp=SP_BASE; op_ready=1; done, pc_load, err_*, mem_req, mem_we = 0; rd_data, pc_value, mem_addr, mem_wdata = 0.
- Accept a command on a rising edge with op_valid && op_ready. Latch op_code, op_data and op_target at that edge. Inputs are ignored outside IDLE.
- FSM states: IDLE, MEM, RESP.
  - IDLE -> MEM on accept when the command is legal.
  - IDLE -> RESP on accept when the command is illegal.
  - MEM -> RESP on the edge where mem_ack=1.
  - RESP -> IDLE unconditionally.
- PUSH/CALL legality: legal when sp != SP_LIMIT. If legal, MEM drives mem_req=1, mem_we=1, mem_addr=sp-1, mem_wdata=op_data. On ack, sp <= sp-1.
- POP/RET legality: legal when sp != SP_BASE. If legal, MEM drives mem_req=1, mem_we=0, mem_addr=sp. On ack, sp <= sp+1 and the read word is captured.
- mem_req and the address/data/direction outputs are held constant throughout MEM until ack. mem_ack is already valid in the first MEM cycle.
- mem_ack outside MEM is ignored.
- RESP state (one cycle), done=1 plus:
  - POP: rd_data = captured word.
  - CALL: pc_load=1, pc_value=op_target.
  - RET: pc_load=1, pc_value=captured word; rd_data is also updated.
  - Illegal command: err_overflow or err_underflow=1, pc_load=0, sp unchanged, no mem_req ever raised.
- Latency, accept edge to done: 2 cycles with zero-wait memory, +1 cycle per cycle mem_ack is late. Throughput is one command per 3 cycles minimum.
- sp arithmetic is modulo 2^W. Wrap cannot occur while SP_LIMIT < SP_BASE, which is a required parameter constraint.
- Reset mid-MEM: mem_req drops asynchronously and sp returns to SP_BASE. Any ack arriving after reset is ignored.
- op_ready=0 in MEM and RESP. The first IDLE cycle after RESP accepts the next command, so back-to-back commands are allowed.

Test Plan:
- Reset, then PUSH 16'h1015 with immediate ack -> mem_req=1, mem_we=1, addr 16'h03FF, wdata 16'h1015; done 2 cycles after accept; sp=16'h03FF.
- POP after the previous step with mem_rdata=16'h1015 and ack delayed 3 cycles -> mem_req held 4 cycles with addr stable at 16'h03FF; done, rd_data=16'h1015, sp=16'h0400.
- CALL op_data=16'h0042, op_target=16'hABA2 -> write 16'h0042 to 16'h03FF; done with pc_load=1, pc_value=16'hABA2. Then RET -> pc_load=1, pc_value=16'h0042, sp=16'h0400.
- POP on empty stack -> no mem_req; done with err_underflow=1; sp stays 16'h0400. Then 16 PUSHes -> sp=16'h03F0; 17th PUSH -> err_overflow=1, no write, sp stays 16'h03F0.
- Assert rst_n=0 mid-MEM of a PUSH -> mem_req=0 same cycle, sp=16'h0400, no done pulse; a late mem_ack after reset release is ignored.
- Hold op_valid=1 during MEM with a different op_code -> not accepted; op_ready=0 until after RESP, then the new command is accepted in the next IDLE cycle.

Source files
------------

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
//
// Sequencer for the CPU stack. Takes PUSH / POP / CALL / RET commands from
// the control unit, owns the stack pointer, runs the single-port data-memory
// handshake and produces a PC load on CALL / RET. When a command would
// overflow or underflow the stack, it is refused with an error flag and memory
// is never touched.
//
// The stack is full-descending. sp points at the last pushed word:
//   sp == SP_BASE  : stack empty
//   sp == SP_LIMIT : stack full
// SP_LIMIT must be below SP_BASE, so sp arithmetic never wraps.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   op_valid      in   command request
//   op_ready      out  command can be accepted (high only in IDLE)
//   op_code       in   00 PUSH, 01 POP, 10 CALL, 11 RET
//   op_data       in   PUSH data / CALL return address
//   op_target     in   CALL jump target
//   done          out  one-cycle completion pulse
//   rd_data       out  POP/RET read word, held until the next POP/RET completes
//   pc_load       out  one-cycle PC load strobe, coincident with done
//   pc_value      out  PC value for pc_load
//   err_overflow  out  done-cycle flag: PUSH/CALL refused, stack full
//   err_underflow out  done-cycle flag: POP/RET refused, stack empty
//   mem_req       out  memory access request
//   mem_we        out  1 = write, 0 = read
//   mem_addr      out  memory address
//   mem_wdata     out  memory write data
//   mem_rdata     in   memory read data, valid when mem_ack = 1
//   mem_ack       in   memory access complete
//   sp            out  current stack pointer
//   state_dbg     out  current FSM state (IDLE=0, MEM=1, RESP=2)
//
// Handshakes
//   Command side: a command transfers on a rising edge where
//   op_valid && op_ready. op_ready is high only in IDLE, and the command
//   fields are latched on that edge. op_valid and the command fields are
//   ignored at all other times.
//   Memory side: mem_req rises together with mem_we, mem_addr and mem_wdata.
//   All four stay constant until a rising edge samples mem_ack = 1. That edge
//   ends the access, and mem_rdata is taken on that same edge. mem_ack may
//   already be high in the first cycle of the request. mem_ack is ignored
//   while no request is outstanding.
// ---------------------------------------------------------------------------
module stack_ctrl #(
    parameter int           W        = 16,
    parameter logic [W-1:0] SP_BASE  = 16'h0400,
    parameter logic [W-1:0] SP_LIMIT = 16'h03F0
) (
    input  logic         clk,
    input  logic         rst_n,

    // command interface
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [1:0]   op_code,
    input  logic [W-1:0] op_data,
    input  logic [W-1:0] op_target,

    // response interface
    output logic         done,
    output logic [W-1:0] rd_data,
    output logic         pc_load,
    output logic [W-1:0] pc_value,
    output logic         err_overflow,
    output logic         err_underflow,

    // data memory interface
    output logic         mem_req,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata,
    input  logic         mem_ack,

    // status / debug
    output logic [W-1:0] sp,
    output logic [1:0]   state_dbg
);

    // -----------------------------------------------------------------------
    // Command encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    localparam logic [W-1:0] SP_STEP = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a command, op_ready high
        MEM  = 2'd1,   // memory access outstanding, waiting for mem_ack
        RESP = 2'd2    // single response cycle, done high
    } state_t;

    state_t       state;
    logic [1:0]   cmd_code;     // latched op_code of the command in flight
    logic [W-1:0] cmd_target;   // latched op_target (used by CALL)

    // -----------------------------------------------------------------------
    // Command decode (combinational, used only on the accept edge)
    // -----------------------------------------------------------------------
    logic         accept;
    logic         is_write_op;  // PUSH or CALL. Both write one word.
    logic         stack_full;
    logic         stack_empty;
    logic         cmd_legal;
    logic [W-1:0] sp_dec;
    logic [W-1:0] sp_inc;

    always_comb begin
        accept      = op_valid && op_ready;
        // PUSH (00) and CALL (10) differ from POP (01) / RET (11) in bit 0
        is_write_op = (op_code[0] == 1'b0);
        stack_full  = (sp == SP_LIMIT);
        stack_empty = (sp == SP_BASE);
        cmd_legal   = is_write_op ? !stack_full : !stack_empty;
        sp_dec      = sp - SP_STEP;
        sp_inc      = sp + SP_STEP;
    end

    assign state_dbg = state;

    // -----------------------------------------------------------------------
    // Sequencer. All outputs are registered here. Each output changes only on
    // a state transition, so each output has a clean phase relation to the
    // state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sp            <= SP_BASE;
            op_ready      <= 1'b1;
            done          <= 1'b0;
            pc_load       <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            rd_data       <= '0;
            pc_value      <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cmd_code      <= OP_PUSH;
            cmd_target    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_code   <= op_code;
                        cmd_target <= op_target;
                        // mem_wdata holds the latched op_data for the whole access
                        mem_wdata  <= op_data;
                        op_ready   <= 1'b0;
                        if (cmd_legal) begin
                            state    <= MEM;
                            mem_req  <= 1'b1;
                            mem_we   <= is_write_op;
                            // A write goes to the next free slot below sp.
                            // A read takes the top word at sp.
                            mem_addr <= is_write_op ? sp_dec : sp;
                        end else begin
                            // A refused command goes straight to the response
                            // cycle. sp and memory stay untouched.
                            state         <= RESP;
                            done          <= 1'b1;
                            err_overflow  <= is_write_op;
                            err_underflow <= !is_write_op;
                        end
                    end
                end

                MEM: begin
                    // Request fields stay frozen until the acknowledging edge
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        case (cmd_code)
                            OP_PUSH: begin
                                sp <= sp_dec;
                            end
                            OP_CALL: begin
                                sp       <= sp_dec;
                                pc_load  <= 1'b1;
                                pc_value <= cmd_target;
                            end
                            OP_POP: begin
                                sp      <= sp_inc;
                                rd_data <= mem_rdata;
                            end
                            OP_RET: begin
                                sp       <= sp_inc;
                                rd_data  <= mem_rdata;
                                pc_load  <= 1'b1;
                                pc_value <= mem_rdata;
                            end
                            default: begin
                                sp <= sp;
                            end
                        endcase
                    end
                end

                RESP: begin
                    // done / pc_load / err_* are one-cycle pulses. The next
                    // command can be accepted in the very next IDLE cycle.
                    state         <= IDLE;
                    done          <= 1'b0;
                    pc_load       <= 1'b0;
                    err_overflow  <= 1'b0;
                    err_underflow <= 1'b0;
                    op_ready      <= 1'b1;
                end

                default: begin
                    // Unreachable encoding: return to a safe idle state
                    state         <= IDLE;
                    done          <= 1'b0;
                    pc_load       <= 1'b0;
                    err_overflow  <= 1'b0;
                    err_underflow <= 1'b0;
                    mem_req       <= 1'b0;
                    mem_we        <= 1'b0;
                    op_ready      <= 1'b1;
                end
            endcase
        end
    end

endmodule
